// File: rtl/input_skew_buffer.sv
// input_skew_buffer: captures a tile of DEPTH operand vectors, then streams
// them into the systolic array edge with lane i delayed i cycles relative to
// lane 0. The tile is retained after streaming so it can be replayed.
module input_skew_buffer #(
    parameter int ARRAYWIDTH = 4,
    parameter int DATASIZE   = 8,
    parameter int DEPTH      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] in_vec,
    input  logic                           start,
    output logic                           busy,
    output logic [ARRAYWIDTH*DATASIZE-1:0] out_vec,
    output logic [ARRAYWIDTH-1:0]          out_lane_valid,
    output logic                           done
);

    localparam int VW  = ARRAYWIDTH * DATASIZE;
    localparam int WCW = $clog2(DEPTH);
    localparam int SCW = $clog2(DEPTH + ARRAYWIDTH);
    localparam logic [WCW-1:0] WR_LAST = WCW'(DEPTH - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(DEPTH + ARRAYWIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FULL   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t               state_q;
    logic [WCW-1:0]       wr_cnt_q;
    logic [SCW-1:0]       sc_q;
    logic [VW-1:0]        mem_q [DEPTH];
    logic                 in_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic [VW-1:0]        out_vec_q;
    logic [ARRAYWIDTH-1:0] out_lane_valid_q;

    logic                 wr_en_d;
    logic [SCW-1:0]       sc_d;
    logic [WCW-1:0]       k_idx_d;
    logic [VW-1:0]        lane_vec_d;
    logic [ARRAYWIDTH-1:0] lane_valid_d;
    logic                 done_d;

    // A write is accepted only while ready and not being flushed.
    assign wr_en_d = in_valid & in_ready_q & ~load_clear;

    // Skewed view of the tile for the stream index that the next cycle shows:
    // index 0 when launching from FULL, otherwise the current index plus one.
    always_comb begin
        sc_d         = (state_q == S_STREAM) ? (sc_q + SCW'(1)) : '0;
        k_idx_d      = '0;
        lane_vec_d   = '0;
        lane_valid_d = '0;
        for (int i = 0; i < ARRAYWIDTH; i++) begin
            if ((sc_d >= SCW'(i)) && ((sc_d - SCW'(i)) < SCW'(DEPTH))) begin
                k_idx_d         = WCW'(sc_d - SCW'(i));
                lane_valid_d[i] = 1'b1;
                lane_vec_d[i*DATASIZE +: DATASIZE] = mem_q[k_idx_d][i*DATASIZE +: DATASIZE];
            end else begin
                lane_valid_d[i] = 1'b0;
                lane_vec_d[i*DATASIZE +: DATASIZE] = '0;
            end
        end
        done_d = (sc_d == SC_LAST);
    end

    // Tile storage; intentionally not reset, contents are rewritten on every load.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[wr_cnt_q] <= in_vec;
        end
    end

    // Control FSM with registered handshake and stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            wr_cnt_q         <= '0;
            sc_q             <= '0;
            in_ready_q       <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            out_vec_q        <= '0;
            out_lane_valid_q <= '0;
        end else if (load_clear) begin
            state_q          <= S_IDLE;
            wr_cnt_q         <= '0;
            sc_q             <= '0;
            in_ready_q       <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            out_vec_q        <= '0;
            out_lane_valid_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_en_d) begin
                        wr_cnt_q <= wr_cnt_q + WCW'(1);
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (wr_en_d) begin
                        if (wr_cnt_q == WR_LAST) begin
                            wr_cnt_q   <= '0;
                            state_q    <= S_FULL;
                            in_ready_q <= 1'b0;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + WCW'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        state_q          <= S_STREAM;
                        sc_q             <= '0;
                        busy_q           <= 1'b1;
                        out_vec_q        <= lane_vec_d;
                        out_lane_valid_q <= lane_valid_d;
                        done_q           <= done_d;
                    end
                end
                S_STREAM: begin
                    if (sc_q == SC_LAST) begin
                        state_q          <= S_FULL;
                        sc_q             <= '0;
                        busy_q           <= 1'b0;
                        done_q           <= 1'b0;
                        out_vec_q        <= '0;
                        out_lane_valid_q <= '0;
                    end else begin
                        sc_q             <= sc_d;
                        out_vec_q        <= lane_vec_d;
                        out_lane_valid_q <= lane_valid_d;
                        done_q           <= done_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign out_vec        = out_vec_q;
    assign out_lane_valid = out_lane_valid_q;

endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed testbench for input_skew_buffer (ARRAYWIDTH=4, DATASIZE=8, DEPTH=8).
module tb_input_skew_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        start;
    logic        busy;
    logic [31:0] out_vec;
    logic [3:0]  out_lane_valid;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    input_skew_buffer #(.ARRAYWIDTH(4), .DATASIZE(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .load_clear(load_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .start(start), .busy(busy), .out_vec(out_vec),
        .out_lane_valid(out_lane_valid), .done(done)
    );

    always #5 clk = ~clk;

    // Entry k, lane i holds base + 16*k + i.
    function automatic logic [31:0] mk_vec(input logic [7:0] base, input int k);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = base + 8'(16*k) + 8'(i);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write n entries starting at entry first_k; optionally idle one cycle after each.
    task automatic load_tile(input logic [7:0] base, input int first_k, input int n, input bit toggle);
        for (int k = first_k; k < first_k + n; k++) begin
            in_valid = 1'b1;
            in_vec   = mk_vec(base, k);
            nvec++;
            if (in_ready !== 1'b1) begin
                nerr++;
                $display("FAIL load_ready k=%0d got %b want 1", k, in_ready);
            end
            tick();
            if (toggle) begin
                in_valid = 1'b0;
                in_vec   = 32'hDEAD_BEEF;
                tick();
            end
        end
        in_valid = 1'b0;
        nvec++;
        if (in_ready !== ((first_k + n) < 8)) begin
            nerr++;
            $display("FAIL load_end_ready got %b want %b", in_ready, ((first_k + n) < 8));
        end
    endtask

    // Launch a stream now and check every cycle; optional spurious start at
    // stream cycle spur_j and load_clear at stream cycle abort_j.
    task automatic run_stream(input logic [7:0] base, input int spur_j, input int abort_j);
        logic [3:0]  ev;
        logic [31:0] ed;
        int k;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            ev = '0;
            ed = '0;
            for (int i = 0; i < 4; i++) begin
                k = j - 1 - i;
                if (k >= 0 && k < 8) begin
                    ev[i]       = 1'b1;
                    ed[i*8 +: 8] = base + 8'(16*k) + 8'(i);
                end
            end
            nvec++;
            if (out_lane_valid !== ev) begin
                nerr++;
                $display("FAIL stream_valid j=%0d got %b want %b", j, out_lane_valid, ev);
            end
            nvec++;
            if (out_vec !== ed) begin
                nerr++;
                $display("FAIL stream_data j=%0d got %h want %h", j, out_vec, ed);
            end
            nvec++;
            if (done !== (j == 11)) begin
                nerr++;
                $display("FAIL stream_done j=%0d got %b want %b", j, done, (j == 11));
            end
            nvec++;
            if (busy !== 1'b1) begin
                nerr++;
                $display("FAIL stream_busy j=%0d got %b want 1", j, busy);
            end
            if (j == abort_j) begin
                load_clear = 1'b1;
                tick();
                load_clear = 1'b0;
                nvec++;
                if ({out_lane_valid, out_vec, busy, done, in_ready} !== {4'h0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
                    nerr++;
                    $display("FAIL abort_outputs got v=%b d=%h b=%b dn=%b r=%b want all 0 ready 1",
                             out_lane_valid, out_vec, busy, done, in_ready);
                end
                return;
            end
            start = (j == spur_j);
            tick();
            start = 1'b0;
        end
        nvec++;
        if ({out_lane_valid, out_vec, busy, done, in_ready} !== {4'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL stream_after got v=%b d=%h b=%b dn=%b r=%b want all 0",
                     out_lane_valid, out_vec, busy, done, in_ready);
        end
    endtask

    task automatic do_clear();
        load_clear = 1'b1;
        tick();
        load_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_clear = 1'b0; in_valid = 1'b0; in_vec = '0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nvec++;
        if ({in_ready, busy, done, out_lane_valid, out_vec} !== {1'b1, 1'b0, 1'b0, 4'h0, 32'h0}) begin
            nerr++;
            $display("FAIL reset_state got r=%b b=%b dn=%b v=%b d=%h want r=1 rest 0",
                     in_ready, busy, done, out_lane_valid, out_vec);
        end
    endtask

    task automatic test_load_stream();
        load_tile(8'h00, 0, 8, 1'b0);
        tick();
        run_stream(8'h00, 0, 0);
    endtask

    task automatic test_toggle_load();
        do_clear();
        load_tile(8'h00, 0, 8, 1'b1);
        run_stream(8'h00, 0, 0);
    endtask

    task automatic test_ignored_start();
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if ({busy, in_ready} !== 2'b01) begin
            nerr++;
            $display("FAIL start_idle got b=%b r=%b want b=0 r=1", busy, in_ready);
        end
        load_tile(8'h20, 0, 3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if ({busy, out_lane_valid} !== 5'b0) begin
            nerr++;
            $display("FAIL start_load got b=%b v=%b want 0", busy, out_lane_valid);
        end
        load_tile(8'h20, 3, 5, 1'b0);
        run_stream(8'h20, 5, 0);
        run_stream(8'h20, 0, 0);
    endtask

    task automatic test_clear_mid_stream();
        run_stream(8'h20, 0, 5);
        for (int n = 0; n < 8; n++) begin
            tick();
            nvec++;
            if ({done, busy, out_lane_valid} !== 6'b0) begin
                nerr++;
                $display("FAIL abort_quiet n=%0d got dn=%b b=%b v=%b want 0", n, done, busy, out_lane_valid);
            end
        end
        load_tile(8'h80, 0, 8, 1'b0);
        run_stream(8'h80, 0, 0);
    endtask

    task automatic test_async_reset();
        do_clear();
        load_tile(8'h00, 0, 3, 1'b0);
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({in_ready, busy, out_lane_valid, out_vec} !== {1'b1, 1'b0, 4'h0, 32'h0}) begin
            nerr++;
            $display("FAIL rst_load got r=%b b=%b v=%b d=%h want r=1 rest 0", in_ready, busy, out_lane_valid, out_vec);
        end
        #2 rst = 1'b0;
        tick();
        load_tile(8'h00, 0, 7, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if ({busy, out_lane_valid} !== 5'b0) begin
            nerr++;
            $display("FAIL start_7writes got b=%b v=%b want 0", busy, out_lane_valid);
        end
        load_tile(8'h00, 7, 1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        nvec++;
        if (out_lane_valid !== 4'b0111) begin
            nerr++;
            $display("FAIL pre_rst_valid got %b want 0111", out_lane_valid);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if ({out_lane_valid, out_vec, busy, done} !== {4'h0, 32'h0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL rst_stream got v=%b d=%h b=%b dn=%b want 0", out_lane_valid, out_vec, busy, done);
        end
        #2 rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if ({in_ready, busy} !== 2'b10) begin
            nerr++;
            $display("FAIL post_rst got r=%b b=%b want r=1 b=0", in_ready, busy);
        end
    endtask

    task automatic test_clear_with_write();
        do_clear();
        load_tile(8'h40, 0, 2, 1'b0);
        in_valid   = 1'b1;
        in_vec     = 32'hFFFF_FFFF;
        load_clear = 1'b1;
        tick();
        in_valid   = 1'b0;
        load_clear = 1'b0;
        nvec++;
        if ({in_ready, busy} !== 2'b10) begin
            nerr++;
            $display("FAIL clr_write got r=%b b=%b want r=1 b=0", in_ready, busy);
        end
        load_tile(8'h40, 0, 8, 1'b0);
        run_stream(8'h40, 0, 0);
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_toggle_load();
        test_ignored_start();
        test_clear_mid_stream();
        test_async_reset();
        test_clear_with_write();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
